// File: rtl/ipml_prefetch_pkg_v2_0.sv
// Shared sizing helpers and legal-range checks for the
// read-side prefetch stage.
package ipml_prefetch_pkg_v2_0;

   localparam int LAT_MIN    = 1;
   localparam int LAT_MAX    = 3;
   localparam int DEPTH_MIN  = 2;
   localparam int DEPTH_MAX  = 8;
   localparam int DATA_W_MAX = 1152;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r++;
      end
      return r;
   endfunction

   function automatic int cnt_w(input int depth);
      return clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

   function automatic bit cfg_ok(input int dw,
                                 input int lat,
                                 input int depth);
      return (dw >= 1) && (dw <= DATA_W_MAX) &&
             (lat >= LAT_MIN) && (lat <= LAT_MAX) &&
             (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
   endfunction

   localparam int DEF_PF_DEPTH = 2;
   localparam int DEF_CNT_W    = cnt_w(DEF_PF_DEPTH);
   localparam int DEF_PTR_W    = ptr_w(DEF_PF_DEPTH);

endpackage

// File: rtl/ipml_prefetch_ring_v2_0.sv
// Register ring buffer holding prefetched words; write and
// pop ports with an occupancy count, clr empties it.
module ipml_prefetch_ring_v2_0
   import ipml_prefetch_pkg_v2_0::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = cnt_w(DEPTH)
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic              clr,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = ptr_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Explicit wrap so non-power-of-2 depths stay in range.
   function automatic logic [PTR_W-1:0] nxt(
      input logic [PTR_W-1:0] p
   );
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (pop) rd_ptr <= nxt(rd_ptr);
         unique case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];

   a_no_overflow: assert property (
      @(posedge rd_clk) disable iff (rd_rst)
      (wr && !clr) |-> (count < CNT_W'(DEPTH))
   );

   a_no_underflow: assert property (
      @(posedge rd_clk) disable iff (rd_rst)
      pop |-> (count != '0)
   );

endmodule

// File: rtl/ipml_prefetch_stage_v2_0.sv
// Credit-based read prefetch between an SDP RAM and a
// valid/ready consumer, with flush and occupancy output.
module ipml_prefetch_stage_v2_0
   import ipml_prefetch_pkg_v2_0::*;
#(
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1,
   parameter int PF_DEPTH   = 2,
   parameter int CNT_W      = cnt_w(PF_DEPTH)
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic              ram_empty,
   output logic              ram_rd_en,
   input  logic [DATA_W-1:0] ram_rd_data,
   input  logic              flush,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_vld,
   input  logic              rd_en,
   output logic [CNT_W-1:0]  pf_level
);

   if (!cfg_ok(DATA_W, RD_LATENCY, PF_DEPTH)) begin : g_bad_cfg
      $error("ipml_prefetch_stage_v2_0: illegal parameters");
   end

   localparam int SW = CNT_W + 1;

   logic [RD_LATENCY-1:0] vpipe;
   logic [SW-1:0]         inflight;
   logic [SW-1:0]         credit_use;
   logic                  pop;
   logic                  land;

   assign pop  = rd_vld & rd_en;
   assign land = vpipe[RD_LATENCY-1];

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + SW'(vpipe[i]);
      end
   end

   // A pop in this cycle frees a slot for this cycle's issue.
   assign credit_use = SW'(pf_level) + inflight - SW'(pop);

   assign ram_rd_en = ~rd_rst & ~ram_empty & ~flush &
                      (credit_use < SW'(PF_DEPTH));

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         vpipe <= '0;
      end else if (flush) begin
         vpipe <= '0;
      end else begin
         vpipe <= RD_LATENCY'({vpipe, ram_rd_en});
      end
   end

   ipml_prefetch_ring_v2_0 #(
      .DATA_W (DATA_W),
      .DEPTH  (PF_DEPTH),
      .CNT_W  (CNT_W)
   ) u_ring (
      .rd_clk  (rd_clk),
      .rd_rst  (rd_rst),
      .clr     (flush),
      .wr      (land),
      .wr_data (ram_rd_data),
      .pop     (pop),
      .rd_data (rd_data),
      .count   (pf_level)
   );

   assign rd_vld = (pf_level != '0);

   a_level_bound: assert property (
      @(posedge rd_clk) disable iff (rd_rst)
      (SW'(pf_level) + inflight) <= SW'(PF_DEPTH)
   );

endmodule

// File: tb/tb_ipml_prefetch_stage_v2_0.sv
// Directed bench: four prefetch instances of differing
// latency/depth, each fed by a small RAM/controller model.
module tb_ipml_prefetch_stage_v2_0;

   localparam int N = 4;

   function automatic int lat_of(input int k);
      case (k)
         0:       return 1;
         1:       return 2;
         2:       return 3;
         default: return 2;
      endcase
   endfunction

   function automatic int dep_of(input int k);
      case (k)
         0:       return 2;
         1:       return 3;
         2:       return 2;
         default: return 5;
      endcase
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst      [N];
   logic        flush    [N];
   logic        rd_en    [N];
   int          avail    [N];
   logic        ram_rd_en[N];
   logic        rd_vld   [N];
   logic [31:0] rd_data  [N];
   logic [3:0]  lvl      [N];

   int errors = 0;
   int checks = 0;

   for (genvar k = 0; k < N; k++) begin : g_dut
      localparam int L  = lat_of(k);
      localparam int D  = dep_of(k);
      localparam int CW = $clog2(D + 1);

      logic [31:0]   pipe [L];
      logic          empty;
      logic          en;
      logic          vld;
      logic [31:0]   q;
      logic [CW-1:0] lv;
      int            ptr;

      assign empty = (ptr >= avail[k]);

      // RAM word value equals its read index.
      always_ff @(posedge clk or posedge rst[k]) begin
         if (rst[k]) begin
            ptr <= 0;
            for (int i = 0; i < L; i++) pipe[i] <= '0;
         end else begin
            if (en) begin
               pipe[0] <= 32'(ptr);
               ptr     <= ptr + 1;
            end
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
         end
      end

      ipml_prefetch_stage_v2_0 #(
         .DATA_W     (32),
         .RD_LATENCY (L),
         .PF_DEPTH   (D)
      ) u_dut (
         .rd_clk      (clk),
         .rd_rst      (rst[k]),
         .ram_empty   (empty),
         .ram_rd_en   (en),
         .ram_rd_data (pipe[L-1]),
         .flush       (flush[k]),
         .rd_data     (q),
         .rd_vld      (vld),
         .rd_en       (rd_en[k]),
         .pf_level    (lv)
      );

      assign ram_rd_en[k] = en;
      assign rd_vld[k]    = vld;
      assign rd_data[k]   = q;
      assign lvl[k]       = 4'(lv);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < N; k++) begin
         rst[k] = 1'b1; flush[k] = 1'b0;
         rd_en[k] = 1'b0; avail[k] = 0;
      end
      tick(); tick();
      for (int k = 0; k < N; k++) avail[k] = 5;
      settle();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (rd_vld[k] !== 1'b0 || lvl[k] !== 4'd0) begin
            errors++;
            $display("FAIL reset_vld_lvl k=%0d: vld=%b lvl=%0d want 0/0",
                     k, rd_vld[k], lvl[k]);
         end
         checks++;
         if (rd_data[k] !== 32'd0) begin
            errors++;
            $display("FAIL reset_data k=%0d: got %0h want 0",
                     k, rd_data[k]);
         end
         checks++;
         if (ram_rd_en[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_en k=%0d: got %b want 0",
                     k, ram_rd_en[k]);
         end
      end
      for (int k = 0; k < N; k++) avail[k] = 0;
      tick();
      for (int k = 0; k < N; k++) rst[k] = 1'b0;
      tick();
   endtask

   task automatic test_stream();
      rd_en[0] = 1'b1;
      avail[0] = 8;
      for (int c = 1; c <= 10; c++) begin
         tick();
         checks++;
         if (c == 1 || c == 10) begin
            if (rd_vld[0] !== 1'b0) begin
               errors++;
               $display("FAIL stream_idle c=%0d: vld=%b want 0",
                        c, rd_vld[0]);
            end
         end else if (rd_vld[0] !== 1'b1 ||
                      rd_data[0] !== 32'(c - 2)) begin
            errors++;
            $display("FAIL stream_word c=%0d: vld=%b data=%0d want 1/%0d",
                     c, rd_vld[0], rd_data[0], c - 2);
         end
      end
   endtask

   task automatic test_fill_hold();
      int pulses;
      pulses = 0;
      rd_en[1] = 1'b0;
      avail[1] = 10;
      for (int c = 0; c < 10; c++) begin
         settle();
         if (ram_rd_en[1] === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses != 3) begin
         errors++;
         $display("FAIL fill_pulses: got %0d want 3", pulses);
      end
      checks++;
      if (lvl[1] !== 4'd3 || rd_vld[1] !== 1'b1) begin
         errors++;
         $display("FAIL fill_level: lvl=%0d vld=%b want 3/1",
                  lvl[1], rd_vld[1]);
      end
      checks++;
      if (rd_data[1] !== 32'd0) begin
         errors++;
         $display("FAIL fill_head: got %0d want 0", rd_data[1]);
      end
      rd_en[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (rd_vld[1] !== 1'b1 || rd_data[1] !== 32'(i)) begin
            errors++;
            $display("FAIL b2b_word i=%0d: vld=%b data=%0d want 1/%0d",
                     i, rd_vld[1], rd_data[1], i);
         end
         tick();
      end
      checks++;
      if (rd_vld[1] !== 1'b0 || lvl[1] !== 4'd0) begin
         errors++;
         $display("FAIL b2b_drained: vld=%b lvl=%0d want 0/0",
                  rd_vld[1], lvl[1]);
      end
      rd_en[1] = 1'b0;
   endtask

   task automatic test_under_prov();
      int wh[8];
      int got;
      got = 0;
      for (int i = 0; i < 8; i++) wh[i] = 0;
      rd_en[2] = 1'b1;
      avail[2] = 8;
      for (int c = 0; c < 60 && got < 8; c++) begin
         if (rd_vld[2] === 1'b1) begin
            checks++;
            if (rd_data[2] !== 32'(got)) begin
               errors++;
               $display("FAIL under_order: got %0d want %0d",
                        rd_data[2], got);
            end
            wh[got] = c;
            got++;
         end
         tick();
      end
      checks++;
      if (got != 8) begin
         errors++;
         $display("FAIL under_count: got %0d want 8", got);
      end
      checks++;
      if (wh[0] != 4 || wh[1] != 5) begin
         errors++;
         $display("FAIL under_first: at %0d,%0d want 4,5",
                  wh[0], wh[1]);
      end
      checks++;
      if (wh[2] - wh[0] != 4 || wh[3] - wh[1] != 4) begin
         errors++;
         $display("FAIL under_rate: spacing %0d,%0d want 4,4",
                  wh[2] - wh[0], wh[3] - wh[1]);
      end
      rd_en[2] = 1'b0;
   endtask

   task automatic test_random();
      int exp_w;
      exp_w = 0;
      for (int cyc = 0; cyc < 60000 && exp_w < 10000; cyc++) begin
         if (((cyc / 40) % 4) != 0 && avail[3] < 10000 &&
             $urandom_range(0, 7) != 0)
            avail[3] = avail[3] + 1;
         rd_en[3] = 1'($urandom_range(0, 1));
         settle();
         checks++;
         if (lvl[3] > 4'd5) begin
            errors++;
            $display("FAIL rand_level cyc=%0d: got %0d want <=5",
                     cyc, lvl[3]);
         end
         if (rd_vld[3] === 1'b1 && rd_en[3] === 1'b1) begin
            checks++;
            if (rd_data[3] !== 32'(exp_w)) begin
               errors++;
               $display("FAIL rand_word: got %0d want %0d",
                        rd_data[3], exp_w);
            end
            exp_w++;
         end
         tick();
      end
      checks++;
      if (exp_w != 10000) begin
         errors++;
         $display("FAIL rand_total: got %0d want 10000", exp_w);
      end
      rd_en[3] = 1'b0;
   endtask

   task automatic test_flush();
      int w;
      rd_en[1] = 1'b0;
      avail[1] = 20;
      repeat (4) tick();
      checks++;
      if (lvl[1] !== 4'd2) begin
         errors++;
         $display("FAIL flush_pre_level: got %0d want 2", lvl[1]);
      end
      rd_en[1] = 1'b1;
      flush[1] = 1'b1;
      settle();
      checks++;
      if (ram_rd_en[1] !== 1'b0) begin
         errors++;
         $display("FAIL flush_issue: got %b want 0", ram_rd_en[1]);
      end
      checks++;
      if (rd_vld[1] !== 1'b1 || rd_data[1] !== 32'd10) begin
         errors++;
         $display("FAIL flush_pop: vld=%b data=%0d want 1/10",
                  rd_vld[1], rd_data[1]);
      end
      tick();
      flush[1] = 1'b0;
      checks++;
      if (rd_vld[1] !== 1'b0 || lvl[1] !== 4'd0) begin
         errors++;
         $display("FAIL flush_clear: vld=%b lvl=%0d want 0/0",
                  rd_vld[1], lvl[1]);
      end
      w = 0;
      while (rd_vld[1] !== 1'b1 && w < 10) begin
         tick();
         w++;
      end
      checks++;
      if (w != 3 || rd_data[1] !== 32'd13) begin
         errors++;
         $display("FAIL flush_next: wait=%0d data=%0d want 3/13",
                  w, rd_data[1]);
      end
      tick();
      checks++;
      if (rd_vld[1] !== 1'b1 || rd_data[1] !== 32'd14) begin
         errors++;
         $display("FAIL flush_follow: vld=%b data=%0d want 1/14",
                  rd_vld[1], rd_data[1]);
      end
      rd_en[1] = 1'b0;
      flush[1] = 1'b1;
      tick();
      flush[1] = 1'b0;
   endtask

   task automatic test_async_reset();
      int exp_w;
      int first;
      rd_en[0] = 1'b1;
      avail[0] = 20;
      repeat (4) tick();
      checks++;
      if (rd_vld[0] !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre: vld=%b want 1", rd_vld[0]);
      end
      #3;
      rst[0] = 1'b1;
      #1;
      checks++;
      if (rd_vld[0] !== 1'b0 || ram_rd_en[0] !== 1'b0 ||
          lvl[0] !== 4'd0) begin
         errors++;
         $display("FAIL arst_now: vld=%b en=%b lvl=%0d want 0/0/0",
                  rd_vld[0], ram_rd_en[0], lvl[0]);
      end
      avail[0] = 6;
      tick(); tick();
      rst[0] = 1'b0;
      exp_w = 0;
      first = -1;
      for (int c = 0; c < 30 && exp_w < 6; c++) begin
         if (rd_vld[0] === 1'b1) begin
            if (first < 0) first = c;
            checks++;
            if (rd_data[0] !== 32'(exp_w)) begin
               errors++;
               $display("FAIL arst_word: got %0d want %0d",
                        rd_data[0], exp_w);
            end
            exp_w++;
         end
         tick();
      end
      checks++;
      if (exp_w != 6 || first != 2) begin
         errors++;
         $display("FAIL arst_restart: words=%0d first=%0d want 6/2",
                  exp_w, first);
      end
      rd_en[0] = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fill_hold();
      test_under_prov();
      test_random();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
